result_monitor: RTL

RESULT_MONITOR -- requirements
Module: result_monitor

---
 rtl/result_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/result_monitor.sv
// result_monitor
//   Snoops CPU data-memory writes to collect self-test results. Each result
//   word k lives at BASE_ADDR + 4*k. A write of zero means pass and a nonzero
//   value means fail. A full-word write to DONE_ADDR ends the run with a
//   verdict. If no such write arrives within TIMEOUT_CYCLES, the run ends in
//   TIMEOUT instead. DONE and TIMEOUT hold until reset.
//
//   Optional feature: define RESULT_MONITOR_FIRST_FAIL_EN to capture the
//   index of the first result write that carried a nonzero value. Without
//   it, first_fail_idx and first_fail_vld are tied low.
module result_monitor #(
  parameter int unsigned NUM_TESTS      = 13,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
  parameter logic [31:0] DONE_ADDR      = 32'h0000_01FC,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          d_mem_addr,
  input  logic [31:0]          d_mem_wdata,
  input  logic [3:0]           d_mem_wen,
  output logic [1:0]           state,
  output logic [NUM_TESTS-1:0] written_mask,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 done,
  output logic                 pass,
  output logic                 err_partial,
  output logic [4:0]           first_fail_idx,
  output logic                 first_fail_vld
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_DONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [31:0]      REGION_BYTES = 32'(4 * NUM_TESTS);
  localparam logic [CNT_W-1:0] LAST_CYCLE   = CNT_W'(TIMEOUT_CYCLES - 1);

  // Address and write-type decode for the current bus cycle
  logic                 running;
  logic [31:0]          offset;
  logic                 in_region;
  logic                 full_word;
  logic                 aligned;
  logic                 result_wr;
  logic                 partial_wr;
  logic                 sentinel_wr;
  logic                 timeout_hit;
  logic                 wdata_nz;
  logic [4:0]           word_idx;
  logic [NUM_TESTS-1:0] wr_hit;

  assign running   = (state == ST_RUN);
  assign offset    = d_mem_addr - BASE_ADDR;
  assign in_region = (d_mem_addr >= BASE_ADDR) && (offset < REGION_BYTES);
  assign full_word = (d_mem_wen == 4'b1111);
  assign aligned   = (d_mem_addr[1:0] == 2'b00);
  assign wdata_nz  = |d_mem_wdata;
  assign word_idx  = offset[6:2];

  // A legal result write is full-word, word-aligned, and inside the region.
  // Any other nonzero-enable access to the region is flagged as an error.
  assign result_wr   = running && in_region && full_word && aligned;
  assign partial_wr  = running && in_region && (d_mem_wen != 4'b0000) && !(full_word && aligned);
  assign sentinel_wr = running && full_word && (d_mem_addr == DONE_ADDR);
  // The sentinel takes priority if it lands on the last budgeted cycle.
  assign timeout_hit = running && !sentinel_wr && (cycle_count == LAST_CYCLE);

  // One-hot select of the result word hit by this cycle's write
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
    wr_hit = '0;
    for (int k = 0; k < NUM_TESTS; k++) begin
      wr_hit[k] = result_wr && (word_idx == 5'(k));
    end
  end

  // Run-state FSM; the verdict is registered on the RUN->DONE edge
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so rst_n is tested inside the clocked block and kept out of the sensitivity list.
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
      state <= ST_RUN;
      pass  <= 1'b0;
    end else if (sentinel_wr) begin
      state <= ST_DONE;
      pass  <= (&written_mask) && (fail_mask == '0) && !err_partial;
    end else if (timeout_hit) begin
      state <= ST_TIMEOUT;
    end
  end

  // Result masks and the sticky illegal-write flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written_mask <= '0;
      fail_mask    <= '0;
      err_partial  <= 1'b0;
    end else begin
      if (result_wr) begin
        written_mask <= written_mask | wr_hit;
        fail_mask    <= (fail_mask & ~wr_hit) | (wdata_nz ? wr_hit : '0);
      end
      if (partial_wr) begin
        err_partial <= 1'b1;
      end
    end
  end

  // Cycle counter: counts every cycle spent in RUN, including the exit cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (running) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign done = (state != ST_RUN);

`ifdef RESULT_MONITOR_FIRST_FAIL_EN
  // Capture the first result write carrying a nonzero value; hold until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_fail_idx <= 5'd0;
      first_fail_vld <= 1'b0;
    end else if (result_wr && wdata_nz && !first_fail_vld) begin
      first_fail_idx <= word_idx;
      first_fail_vld <= 1'b1;
    end
  end
`else
  assign first_fail_idx = 5'd0;
  assign first_fail_vld = 1'b0;
`endif

endmodule
